sample_i2s_tx: RTL and testbench

//  Output stage after the dynamics stage. Accepts one signed 16-bit mono sample per

---
 rtl/sample_i2s_tx.sv | 142 ++++++++++++++
 tb/tb_sample_i2s_tx.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sample_i2s_tx.sv
// sample_i2s_tx: sample FIFO followed by an I2S serializer.
// Each mono sample is sent as one stereo frame, with the same word on the left and right slots.
// bclk and lrclk are derived from clk, and every flop in the block is clocked by clk.
//
// state (slot) | meaning
// 0            | LSB of previous right word on sdata, lrclk=0, new word loaded
// 1..16        | left word MSB..LSB
// 17..31       | right word MSB..bit1 (bit0 goes out in the next slot 0)
module sample_i2s_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int BCLK_DIV   = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic signed [15:0]            sample_in,
    input  logic                          sample_ready_in,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          underflow,
    output logic                          i2s_bclk,
    output logic                          i2s_lrclk,
    output logic                          i2s_sdata
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(BCLK_DIV - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [4:0]       SLOT_LAST = 5'd31;

    logic [15:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             bclk_q, bclk_d;
    logic             lrclk_q, lrclk_d;
    logic             sdata_q, sdata_d;
    logic [4:0]       slot_q, slot_d;
    logic [15:0]      frame_word_q, frame_word_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             wrap;
    logic             fall;
    logic             frame_start;
    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;
    logic             push;
    logic [3:0]       bit_idx;

    // Bit-clock divider and slot sequencing.
    always_comb begin
        wrap        = (div_cnt_q == DIV_MAX);
        div_cnt_d   = wrap ? '0 : div_cnt_q + 1'b1;
        bclk_d      = wrap ? ~bclk_q : bclk_q;
        fall        = wrap & bclk_q;
        slot_d      = fall ? slot_q + 5'd1 : slot_q;
        frame_start = fall & (slot_q == SLOT_LAST);
    end

    // FIFO control. A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
    always_comb begin
        fifo_empty  = (level_q == '0);
        fifo_full   = (level_q == LVL_FULL);
        pop         = frame_start & ~fifo_empty;
        push        = sample_ready_in & (~fifo_full | pop);
        overflow_d  = sample_ready_in & ~push;
        underflow_d = frame_start & fifo_empty;
        wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d     = level_q;
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end
    end

    // Serializer data path. Slot s in 1..16 carries bit 16-s, and slot s in 17..31 carries bit 32-s.
    // Both cases reduce to (-s) mod 16.
    always_comb begin
        bit_idx      = 4'd0 - slot_d[3:0];
        frame_word_d = frame_word_q;
        if (frame_start) begin
            frame_word_d = pop ? mem_q[rd_ptr_q] : 16'h0000;
        end
        lrclk_d = lrclk_q;
        sdata_d = sdata_q;
        if (fall) begin
            lrclk_d = slot_d[4];
            // Slot 0 carries the LSB of the outgoing word, which is read before frame_word is reloaded.
            sdata_d = (slot_d == 5'd0) ? frame_word_q[0] : frame_word_q[bit_idx];
        end
    end

    // Sample storage. This array has no reset; occupancy is tracked by level_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= sample_in;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            div_cnt_q    <= '0;
            bclk_q       <= 1'b0;
            lrclk_q      <= 1'b1;
            sdata_q      <= 1'b0;
            slot_q       <= SLOT_LAST;
            frame_word_q <= '0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            div_cnt_q    <= div_cnt_d;
            bclk_q       <= bclk_d;
            lrclk_q      <= lrclk_d;
            sdata_q      <= sdata_d;
            slot_q       <= slot_d;
            frame_word_q <= frame_word_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    assign fifo_level = level_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;
    assign i2s_bclk   = bclk_q;
    assign i2s_lrclk  = lrclk_q;
    assign i2s_sdata  = sdata_q;

endmodule

// File: tb/tb_sample_i2s_tx.sv
// Directed testbench for sample_i2s_tx with FIFO_DEPTH=4 and BCLK_DIV=4.
module tb_sample_i2s_tx;

    logic               clk = 1'b0;
    logic               reset_n;
    logic signed [15:0] sample_in;
    logic               sample_ready_in;
    logic [2:0]         fifo_level;
    logic               overflow;
    logic               underflow;
    logic               i2s_bclk;
    logic               i2s_lrclk;
    logic               i2s_sdata;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] LR_EXP = 32'hFFFF_0000;

    sample_i2s_tx #(.FIFO_DEPTH(4), .BCLK_DIV(4)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .sample_in       (sample_in),
        .sample_ready_in (sample_ready_in),
        .fifo_level      (fifo_level),
        .overflow        (overflow),
        .underflow       (underflow),
        .i2s_bclk        (i2s_bclk),
        .i2s_lrclk       (i2s_lrclk),
        .i2s_sdata       (i2s_sdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected sdata for slots 0..31: previous right LSB, then left MSB..LSB, then right MSB..bit1.
    function automatic logic [31:0] exp_frame(input logic prev, input logic [15:0] w);
        logic [31:0] f;
        f[0] = prev;
        for (int s = 1; s <= 16; s++) f[s] = w[16 - s];
        for (int s = 17; s <= 31; s++) f[s] = w[32 - s];
        return f;
    endfunction

    // Wait for lrclk to fall. On return the bench is one step after the edge that entered slot 0.
    task automatic align();
        logic prev;
        int   n;
        prev = i2s_lrclk;
        n    = 0;
        tick();
        while (!(prev == 1'b1 && i2s_lrclk == 1'b0) && n < 300) begin
            prev = i2s_lrclk;
            tick();
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL align: no lrclk fall within %0d clks, required <300", n);
        end
    endtask

    // Entered while aligned on slot 0. Returns aligned on slot 0 of the following frame.
    // ufc counts underflow pulses over the 256 clks of this frame.
    task automatic capture_frame(output logic [31:0] f, output logic [31:0] lr, output int ufc);
        f[0]  = i2s_sdata;
        lr[0] = i2s_lrclk;
        ufc   = int'(underflow);
        for (int s = 1; s <= 31; s++) begin
            for (int j = 0; j < 8; j++) begin
                tick();
                ufc += int'(underflow);
            end
            f[s]  = i2s_sdata;
            lr[s] = i2s_lrclk;
        end
        for (int j = 0; j < 7; j++) begin
            tick();
            ufc += int'(underflow);
        end
        tick();
    endtask

    task automatic push(input logic [15:0] v);
        sample_ready_in = 1'b1;
        sample_in       = v;
        tick();
        sample_ready_in = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        repeat (9) tick();
        push(16'h1234);
        push(16'h5678);
        push(16'h9ABC);
        repeat (4) tick();
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL rst_level: got %0d expected 0", fifo_level); end
        checks++; if (overflow   !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b expected 0", overflow); end
        checks++; if (underflow  !== 1'b0) begin errors++; $display("FAIL rst_underflow: got %b expected 0", underflow); end
        checks++; if (i2s_bclk   !== 1'b0) begin errors++; $display("FAIL rst_bclk: got %b expected 0", i2s_bclk); end
        checks++; if (i2s_lrclk  !== 1'b1) begin errors++; $display("FAIL rst_lrclk: got %b expected 1", i2s_lrclk); end
        checks++; if (i2s_sdata  !== 1'b0) begin errors++; $display("FAIL rst_sdata: got %b expected 0", i2s_sdata); end
        tick();
        reset_n = 1'b1;
        n = 0;
        while (i2s_bclk == 1'b0 && n < 20) begin
            tick();
            n++;
        end
        checks++; if (n != 4) begin errors++; $display("FAIL rst_first_rise: got %0d clks expected 4", n); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL rst_fifo_discard: got %0d expected 0", fifo_level); end
    endtask

    task automatic test_single();
        logic [31:0] f, lr;
        int          ufc;
        push(16'hA5C3);
        checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL single_level: got %0d expected 1", fifo_level); end
        align();
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL single_pop_level: got %0d expected 0", fifo_level); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL single_no_underflow: got %b expected 0", underflow); end
        capture_frame(f, lr, ufc);
        checks++; if (f !== exp_frame(1'b0, 16'hA5C3)) begin errors++; $display("FAIL single_frame: got %h expected %h", f, exp_frame(1'b0, 16'hA5C3)); end
        checks++; if (lr !== LR_EXP) begin errors++; $display("FAIL single_lrclk: got %h expected %h", lr, LR_EXP); end
        checks++; if (ufc != 0) begin errors++; $display("FAIL single_uf_count: got %0d expected 0", ufc); end
        capture_frame(f, lr, ufc);
        checks++; if (f !== 32'h0000_0001) begin errors++; $display("FAIL single_next_slot0: got %h expected 00000001", f); end
        checks++; if (ufc != 1) begin errors++; $display("FAIL single_next_uf: got %0d expected 1", ufc); end
    endtask

    task automatic test_underflow();
        logic [31:0] f, lr;
        int          ufc;
        for (int k = 0; k < 2; k++) begin
            capture_frame(f, lr, ufc);
            checks++; if (f !== 32'h0) begin errors++; $display("FAIL uf_silence%0d: got %h expected 0", k, f); end
            checks++; if (lr !== LR_EXP) begin errors++; $display("FAIL uf_lrclk%0d: got %h expected %h", k, lr, LR_EXP); end
            checks++; if (ufc != 1) begin errors++; $display("FAIL uf_count%0d: got %0d expected 1", k, ufc); end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] f, lr;
        int          ufc;
        logic [15:0] words [4] = '{16'd1, 16'd2, 16'd3, 16'd4};
        logic        prevs [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        sample_ready_in = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            sample_in = 16'(k);
            tick();
        end
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_level4: got %0d expected 4", fifo_level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0", overflow); end
        sample_in = 16'd5;
        tick();
        sample_ready_in = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got %b expected 1", overflow); end
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_level: got %0d expected 4", fifo_level); end
        tick();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_pulse_end: got %b expected 0", overflow); end
        align();
        for (int k = 0; k < 4; k++) begin
            capture_frame(f, lr, ufc);
            checks++; if (f !== exp_frame(prevs[k], words[k])) begin errors++; $display("FAIL ovf_frame%0d: got %h expected %h", k, f, exp_frame(prevs[k], words[k])); end
            checks++; if (ufc != 0) begin errors++; $display("FAIL ovf_uf%0d: got %0d expected 0", k, ufc); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] f, lr;
        int          ufc;
        logic [15:0] words [5] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h7FFF};
        logic        prevs [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        push(16'h1111);
        push(16'h2222);
        push(16'h3333);
        push(16'h4444);
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL b2b_full: got %0d expected 4", fifo_level); end
        repeat (251) tick();
        push(16'h7FFF);
        checks++; if (i2s_lrclk !== 1'b0) begin errors++; $display("FAIL b2b_at_slot0: got lrclk %b expected 0", i2s_lrclk); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow: got %b expected 0", overflow); end
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL b2b_level: got %0d expected 4", fifo_level); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL b2b_underflow: got %b expected 0", underflow); end
        for (int k = 0; k < 5; k++) begin
            capture_frame(f, lr, ufc);
            checks++; if (f !== exp_frame(prevs[k], words[k])) begin errors++; $display("FAIL b2b_frame%0d: got %h expected %h", k, f, exp_frame(prevs[k], words[k])); end
        end
    endtask

    task automatic test_negative();
        logic [31:0] f, lr;
        int          ufc;
        push(16'h8000);
        align();
        capture_frame(f, lr, ufc);
        checks++; if (f[1] !== 1'b1) begin errors++; $display("FAIL neg_left_msb: got %b expected 1", f[1]); end
        checks++; if (f[16:2] !== 15'h0) begin errors++; $display("FAIL neg_left_rest: got %h expected 0", f[16:2]); end
        checks++; if (f !== 32'h0002_0002) begin errors++; $display("FAIL neg_frame: got %h expected 00020002", f); end
        checks++; if (lr !== LR_EXP) begin errors++; $display("FAIL neg_lrclk: got %h expected %h", lr, LR_EXP); end
    endtask

    initial begin
        reset_n         = 1'b0;
        sample_in       = '0;
        sample_ready_in = 1'b0;
        test_reset();
        test_single();
        test_underflow();
        test_overflow();
        test_back_to_back();
        test_negative();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
